// File: rtl/lpc_axis_serializer.sv
// Serializes wide encoder FIFO words into MSB-first AXI-Stream beats.
// One LOAD bubble separates consecutive words; the FIFO is popped on the final beat.
//
// state | meaning
// IDLE  | no word held; pop the FIFO as soon as it is non-empty
// LOAD  | FIFO read data valid this cycle; capture word and flags
// SEND  | present beats; advance on each TVALID/TREADY handshake
module lpc_axis_serializer #(
    parameter int WORD_WIDTH = 80,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET_N,
    input  logic [WORD_WIDTH-1:0] FIFO_DATA,
    input  logic                  FIFO_LAST,
    input  logic                  FIFO_USER,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_RD_EN,
    output logic [OUT_WIDTH-1:0]  M_TDATA,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic                  M_TLAST,
    output logic                  M_TUSER,
    output logic                  BUSY
);

    localparam int BEATS = WORD_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic                  last_flag;
    logic                  user_flag;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  handshake;
    logic                  final_beat;
    logic                  pop;

    always_comb begin
        handshake  = (state == SEND) && M_TREADY;
        final_beat = handshake && (beat_cnt == LAST_BEAT);
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!FIFO_EMPTY) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (final_beat) begin
                    if (!FIFO_EMPTY) begin
                        pop       = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            shift_reg <= '0;
            last_flag <= 1'b0;
            user_flag <= 1'b0;
            beat_cnt  <= '0;
        end else if (state == LOAD) begin
            shift_reg <= FIFO_DATA;
            last_flag <= FIFO_LAST;
            user_flag <= FIFO_USER;
            beat_cnt  <= '0;
        end else if (handshake) begin
            shift_reg <= shift_reg << OUT_WIDTH;
            beat_cnt  <= final_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // IDLE is the reset state, so the pop must be masked while reset is held.
    assign FIFO_RD_EN = pop && ARESET_N;
    assign M_TVALID   = (state == SEND);
    assign M_TDATA    = shift_reg[WORD_WIDTH-1 -: OUT_WIDTH];
    assign M_TUSER    = (state == SEND) && user_flag && (beat_cnt == '0);
    assign M_TLAST    = (state == SEND) && last_flag && (beat_cnt == LAST_BEAT);
    assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_lpc_axis_serializer.sv
// Randomized bench for lpc_axis_serializer: FIFO model plus a beat-queue reference
// built from word contents; checks data, flags, latency, stalls and reset behaviour.
module tb_lpc_axis_serializer;

    localparam int WW    = 80;
    localparam int OW    = 8;
    localparam int BEATS = WW / OW;

    typedef logic [79:0] val_t;
    typedef struct {
        logic [OW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESET_N = 1'b0;
    logic [WW-1:0] FIFO_DATA = '0;
    logic          FIFO_LAST = 1'b0;
    logic          FIFO_USER = 1'b0;
    logic          FIFO_EMPTY;
    logic          FIFO_RD_EN;
    logic [OW-1:0] M_TDATA;
    logic          M_TVALID;
    logic          M_TREADY = 1'b1;
    logic          M_TLAST;
    logic          M_TUSER;
    logic          BUSY;

    lpc_axis_serializer #(.WORD_WIDTH(WW), .OUT_WIDTH(OW)) dut (
        .ACLK       (ACLK),
        .ARESET_N   (ARESET_N),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_LAST  (FIFO_LAST),
        .FIFO_USER  (FIFO_USER),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RD_EN (FIFO_RD_EN),
        .M_TDATA    (M_TDATA),
        .M_TVALID   (M_TVALID),
        .M_TREADY   (M_TREADY),
        .M_TLAST    (M_TLAST),
        .M_TUSER    (M_TUSER),
        .BUSY       (BUSY)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous FIFO model: one-cycle read latency
    logic [WW+1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);

    always @(posedge ACLK) begin
        if (FIFO_RD_EN) begin
            {FIFO_LAST, FIFO_USER, FIFO_DATA} <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    beat_t exp_q[$];

    task automatic push_word(input logic [WW-1:0] d, input logic l, input logic u);
        beat_t b;
        mem[wr_ptr[7:0]] = {l, u, d};
        for (int i = 0; i < BEATS; i++) begin
            b.d = OW'(d >> (OW * (BEATS - 1 - i)));
            b.u = u && (i == 0);
            b.l = l && (i == BEATS - 1);
            exp_q.push_back(b);
        end
        wr_ptr++;
    endtask

    logic bp_mode = 1'b0;
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            M_TREADY = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor
    int            cyc      = 0;
    int            beat_idx = 0;
    int            first_hs = -1;
    int            last_hs  = -1;
    logic          stall_prev = 1'b0;
    logic [OW-1:0] p_data;
    logic          p_user, p_last;
    beat_t         e_mon;

    always @(negedge ACLK) begin
        cyc++;
        chk("rd_when_empty", val_t'(FIFO_RD_EN && FIFO_EMPTY), val_t'(0));
        if (!ARESET_N) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", val_t'(M_TVALID), val_t'(1));
                chk("hold_data", val_t'(M_TDATA), val_t'(p_data));
                chk("hold_user", val_t'(M_TUSER), val_t'(p_user));
                chk("hold_last", val_t'(M_TLAST), val_t'(p_last));
            end
            if (M_TVALID && M_TREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", val_t'(1), val_t'(0));
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("tdata", val_t'(M_TDATA), val_t'(e_mon.d));
                    chk("tuser", val_t'(M_TUSER), val_t'(e_mon.u));
                    chk("tlast", val_t'(M_TLAST), val_t'(e_mon.l));
                end
                beat_idx = (beat_idx == BEATS - 1) ? 0 : beat_idx + 1;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            stall_prev = M_TVALID && !M_TREADY;
            p_data = M_TDATA;
            p_user = M_TUSER;
            p_last = M_TLAST;
        end
    end

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY || !FIFO_EMPTY) && n < max) begin
            @(posedge ACLK);
            #2;
            n++;
        end
        chk("drain_done", val_t'(n < max), val_t'(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tvalid"}, val_t'(M_TVALID), val_t'(0));
        chk({tag, "_tdata"}, val_t'(M_TDATA), val_t'(0));
        chk({tag, "_tlast"}, val_t'(M_TLAST), val_t'(0));
        chk({tag, "_tuser"}, val_t'(M_TUSER), val_t'(0));
        chk({tag, "_busy"}, val_t'(BUSY), val_t'(0));
        chk({tag, "_rd_en"}, val_t'(FIFO_RD_EN), val_t'(0));
    endtask

    initial begin
        int p0;
        int n;
        logic [WW-1:0] w;

        #1;
        check_all_zero("rst");
        repeat (2) @(posedge ACLK);
        #2;
        ARESET_N = 1'b1;

        // Empty FIFO for 20 cycles
        repeat (20) begin
            @(negedge ACLK);
            #1;
            chk("empty_rd_en", val_t'(FIFO_RD_EN), val_t'(0));
            chk("empty_tvalid", val_t'(M_TVALID), val_t'(0));
            chk("empty_busy", val_t'(BUSY), val_t'(0));
        end

        // Single word with first-word latency
        p0 = pops;
        @(posedge ACLK);
        #2;
        push_word(80'h00112233445566778899, 1'b1, 1'b1);
        #1;
        chk("lat_rd_en", val_t'(FIFO_RD_EN), val_t'(1));
        chk("lat_n_tvalid", val_t'(M_TVALID), val_t'(0));
        @(posedge ACLK);
        #2;
        chk("lat_load_tvalid", val_t'(M_TVALID), val_t'(0));
        chk("lat_load_busy", val_t'(BUSY), val_t'(1));
        chk("lat_load_rd_en", val_t'(FIFO_RD_EN), val_t'(0));
        @(posedge ACLK);
        #2;
        chk("lat_send_tvalid", val_t'(M_TVALID), val_t'(1));
        chk("lat_send_tdata", val_t'(M_TDATA), val_t'(8'h00));
        chk("lat_send_tuser", val_t'(M_TUSER), val_t'(1));
        wait_drain(100);
        chk("single_pops", val_t'(pops - p0), val_t'(1));
        chk("single_busy", val_t'(BUSY), val_t'(0));

        // Back-to-back: 3 words, one bubble between words
        p0 = pops;
        first_hs = -1;
        @(posedge ACLK);
        #2;
        for (int i = 0; i < 3; i++) begin
            w = {$urandom, $urandom, $urandom};
            push_word(w, i == 2, 1'b0);
        end
        wait_drain(200);
        chk("b2b_span", val_t'(last_hs - first_hs), val_t'(3 * BEATS + 1));
        chk("b2b_pops", val_t'(pops - p0), val_t'(3));

        // Flag independence
        @(posedge ACLK);
        #2;
        push_word({$urandom, $urandom, $urandom}, 1'b1, 1'b0);
        push_word({$urandom, $urandom, $urandom}, 1'b0, 1'b1);
        wait_drain(200);

        // Reset mid-word after beats 0..4 of word A; word B queued behind it
        @(posedge ACLK);
        #2;
        push_word({$urandom, $urandom, $urandom}, 1'b1, 1'b1);
        push_word(80'hA0A1A2A3A4A5A6A7A8A9, 1'b1, 1'b1);
        n = 0;
        while (beat_idx != 5 && n < 200) begin
            @(posedge ACLK);
            #2;
            n++;
        end
        chk("mid_reach", val_t'(n < 200), val_t'(1));
        for (int i = 0; i < BEATS - 5; i++) void'(exp_q.pop_front());
        beat_idx = 0;
        ARESET_N = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(posedge ACLK);
        #2;
        ARESET_N = 1'b1;
        wait_drain(200);

        // Backpressure with random words and random gaps
        bp_mode = 1'b1;
        push_word(80'h00112233445566778899, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(0, 14);
            repeat (n) @(posedge ACLK);
            #2;
            push_word({$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
        wait_drain(5000);
        bp_mode = 1'b0;

        repeat (3) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
